// File: rtl/hbm_burst_split_pkg.sv
// Shared constants, types and the sub-burst sizing helper for the HBM burst splitter.
package hbm_split_pkg;

  localparam int DEF_DATA_BITS = 512;
  localparam int BEAT_BYTES    = DEF_DATA_BITS / 8;
  localparam int PAGE_BYTES    = 4096;

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } split_state_e;

  typedef logic [1:0] resp_t;

  // Beats in the next sub-burst: limited by what is left, the burst cap and the 4 KB page.
  // Page room rounds up so an unaligned start still yields at least one beat.
  function automatic logic [8:0] chunk_len(input logic [11:0] addr,
                                           input logic [8:0]  rem,
                                           input int          max_beats  = 16,
                                           input int          beat_bytes = BEAT_BYTES);
    int room;
    int c;
    room = (PAGE_BYTES - int'(addr) + beat_bytes - 1) / beat_bytes;
    c    = int'(rem);
    if (max_beats < c) c = max_beats;
    if (room < c) c = room;
    return 9'(c);
  endfunction

endpackage

// File: rtl/hbm_burst_split_if.sv
// AXI4 subset (AR/AW/W/R/B) carried between the splitter and its neighbours.
interface hbm_burst_split_if
  import hbm_split_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS
) ();

  logic [63:0]            araddr;
  logic [7:0]             arlen;
  logic                   arvalid;
  logic                   arready;

  logic [63:0]            awaddr;
  logic [7:0]             awlen;
  logic                   awvalid;
  logic                   awready;

  logic [DATA_BITS-1:0]   wdata;
  logic [DATA_BITS/8-1:0] wstrb;
  logic                   wlast;
  logic                   wvalid;
  logic                   wready;

  logic [DATA_BITS-1:0]   rdata;
  logic [1:0]             rresp;
  logic                   rlast;
  logic                   rvalid;
  logic                   rready;

  logic [1:0]             bresp;
  logic                   bvalid;
  logic                   bready;

  modport master (
    output araddr, arlen, arvalid, input arready,
    output awaddr, awlen, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  rdata, rresp, rlast, rvalid, output rready,
    input  bresp, bvalid, output bready
  );

  modport slave (
    input  araddr, arlen, arvalid, output arready,
    input  awaddr, awlen, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output rdata, rresp, rlast, rvalid, input rready,
    output bresp, bvalid, input bready
  );

endinterface

// File: rtl/hbm_burst_split_queue.sv
// Small synchronous FIFO tracking per-sub-burst information; pop frees a slot for a same-cycle push.
module hbm_split_queue #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/hbm_burst_split.sv
// Splits long AXI4 INCR bursts into HBM-legal sub-bursts (<= MAX_BEATS, no 4 KB crossing),
// regenerating wlast, masking intermediate rlast and merging sub-burst write responses.
module hbm_burst_split
  import hbm_split_pkg::*;
#(
  parameter int MAX_BEATS = 16,
  parameter int QDEPTH    = 8,
  parameter int DATA_BITS = DEF_DATA_BITS
) (
  input  logic                aclk,
  input  logic                areset,
  hbm_burst_split_if.slave    s_axi,
  hbm_burst_split_if.master   m_axi
);

  localparam int BEAT_B     = DATA_BITS / 8;
  localparam int BEAT_SHIFT = $clog2(BEAT_B);

  function automatic resp_t resp_max(input resp_t a, input resp_t b);
    return (a > b) ? a : b;
  endfunction

  // Request acceptance stays off while reset is held and opens one cycle after release.
  logic run;
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) run <= 1'b0;
    else        run <= 1'b1;
  end

  logic wlast_unused;
  assign wlast_unused = s_axi.wlast;

  // ---------------- read address splitter ----------------
  split_state_e ar_state, ar_next;
  logic [63:0]  ar_addr;
  logic [8:0]   ar_rem;
  logic [8:0]   ar_chunk;
  logic         ar_accept, ar_issue;
  logic         rq_full, rq_empty, rq_head, rq_pop;

  assign ar_chunk = chunk_len(ar_addr[11:0], ar_rem, MAX_BEATS, BEAT_B);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) ar_state <= IDLE;
    else        ar_state <= ar_next;
  end

  always_comb begin
    ar_next       = ar_state;
    s_axi.arready = 1'b0;
    m_axi.arvalid = 1'b0;
    ar_accept     = 1'b0;
    ar_issue      = 1'b0;
    case (ar_state)
      IDLE: begin
        s_axi.arready = run;
        if (run && s_axi.arvalid) begin
          ar_accept = 1'b1;
          ar_next   = SPLIT;
        end
      end
      SPLIT: begin
        m_axi.arvalid = ~rq_full;
        if (!rq_full && m_axi.arready) begin
          ar_issue = 1'b1;
          if (ar_rem == ar_chunk) ar_next = IDLE;
        end
      end
      default: ar_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (ar_accept) begin
      ar_addr <= s_axi.araddr;
      ar_rem  <= {1'b0, s_axi.arlen} + 9'd1;
    end else if (ar_issue) begin
      ar_addr <= ar_addr + (64'(ar_chunk) << BEAT_SHIFT);
      ar_rem  <= ar_rem - ar_chunk;
    end
  end

  assign m_axi.araddr = ar_addr;
  assign m_axi.arlen  = 8'(ar_chunk - 9'd1);

  hbm_split_queue #(.WIDTH(1), .DEPTH(QDEPTH)) u_rq (
    .clk   (aclk),
    .rst   (areset),
    .push  (ar_issue),
    .din   (ar_rem == ar_chunk),
    .pop   (rq_pop),
    .head  (rq_head),
    .full  (rq_full),
    .empty (rq_empty)
  );

  // ---------------- read data ----------------
  assign s_axi.rdata  = m_axi.rdata;
  assign s_axi.rresp  = m_axi.rresp;
  assign s_axi.rvalid = m_axi.rvalid;
  assign m_axi.rready = s_axi.rready;
  assign s_axi.rlast  = m_axi.rlast & rq_head & ~rq_empty;
  assign rq_pop       = m_axi.rvalid & s_axi.rready & m_axi.rlast;

  // ---------------- write address splitter ----------------
  split_state_e aw_state, aw_next;
  logic [63:0]  aw_addr;
  logic [8:0]   aw_rem;
  logic [8:0]   aw_chunk;
  logic         aw_accept, aw_issue, aw_room;
  logic         wq_full, wq_empty, wq_pop;
  logic [7:0]   wq_head;
  logic         bq_full, bq_empty, bq_head, bq_pop;

  assign aw_chunk = chunk_len(aw_addr[11:0], aw_rem, MAX_BEATS, BEAT_B);
  assign aw_room  = ~wq_full & ~bq_full;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) aw_state <= IDLE;
    else        aw_state <= aw_next;
  end

  always_comb begin
    aw_next       = aw_state;
    s_axi.awready = 1'b0;
    m_axi.awvalid = 1'b0;
    aw_accept     = 1'b0;
    aw_issue      = 1'b0;
    case (aw_state)
      IDLE: begin
        s_axi.awready = run;
        if (run && s_axi.awvalid) begin
          aw_accept = 1'b1;
          aw_next   = SPLIT;
        end
      end
      SPLIT: begin
        m_axi.awvalid = aw_room;
        if (aw_room && m_axi.awready) begin
          aw_issue = 1'b1;
          if (aw_rem == aw_chunk) aw_next = IDLE;
        end
      end
      default: aw_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (aw_accept) begin
      aw_addr <= s_axi.awaddr;
      aw_rem  <= {1'b0, s_axi.awlen} + 9'd1;
    end else if (aw_issue) begin
      aw_addr <= aw_addr + (64'(aw_chunk) << BEAT_SHIFT);
      aw_rem  <= aw_rem - aw_chunk;
    end
  end

  assign m_axi.awaddr = aw_addr;
  assign m_axi.awlen  = 8'(aw_chunk - 9'd1);

  hbm_split_queue #(.WIDTH(8), .DEPTH(QDEPTH)) u_wq (
    .clk   (aclk),
    .rst   (areset),
    .push  (aw_issue),
    .din   (8'(aw_chunk - 9'd1)),
    .pop   (wq_pop),
    .head  (wq_head),
    .full  (wq_full),
    .empty (wq_empty)
  );

  hbm_split_queue #(.WIDTH(1), .DEPTH(QDEPTH)) u_bq (
    .clk   (aclk),
    .rst   (areset),
    .push  (aw_issue),
    .din   (aw_rem == aw_chunk),
    .pop   (bq_pop),
    .head  (bq_head),
    .full  (bq_full),
    .empty (bq_empty)
  );

  // ---------------- write data: gated pass-through with regenerated wlast ----------------
  logic [7:0] wcnt;
  logic       w_hs;

  assign m_axi.wvalid = s_axi.wvalid & ~wq_empty;
  assign s_axi.wready = m_axi.wready & ~wq_empty;
  assign m_axi.wdata  = s_axi.wdata;
  assign m_axi.wstrb  = s_axi.wstrb;
  assign m_axi.wlast  = ~wq_empty & (wcnt == wq_head);
  assign w_hs         = m_axi.wvalid & m_axi.wready;
  assign wq_pop       = w_hs & m_axi.wlast;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset)      wcnt <= '0;
    else if (wq_pop) wcnt <= '0;
    else if (w_hs)   wcnt <= wcnt + 8'd1;
  end

  // ---------------- write response merge ----------------
  logic  bvalid_q;
  resp_t bresp_q;
  resp_t acc;
  resp_t b_merged;
  logic  b_hs;
  logic  b_final;

  assign m_axi.bready = ~bvalid_q;
  assign b_hs         = m_axi.bvalid & ~bvalid_q;
  assign b_merged     = resp_max(acc, m_axi.bresp);
  assign b_final      = bq_head & ~bq_empty;
  assign bq_pop       = b_hs;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      bvalid_q <= 1'b0;
      acc      <= '0;
    end else begin
      if (bvalid_q && s_axi.bready) bvalid_q <= 1'b0;
      if (b_hs) begin
        if (b_final) begin
          bvalid_q <= 1'b1;
          acc      <= '0;
        end else begin
          acc <= b_merged;
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (b_hs && b_final) bresp_q <= b_merged;
  end

  assign s_axi.bvalid = bvalid_q;
  assign s_axi.bresp  = bresp_q;

endmodule

// File: tb/tb_hbm_burst_split.sv
// Directed bench for hbm_burst_split: table of read splits plus hand-written write/stall/reset sequences.
module tb_hbm_burst_split;
  import hbm_split_pkg::*;

  logic aclk;
  logic areset;
  int   checks;
  int   errors;

  hbm_burst_split_if #(.DATA_BITS(512)) s_if ();
  hbm_burst_split_if #(.DATA_BITS(512)) m_if ();

  hbm_burst_split #(.MAX_BEATS(16), .QDEPTH(8), .DATA_BITS(512)) dut (
    .aclk   (aclk),
    .areset (areset),
    .s_axi  (s_if),
    .m_axi  (m_if)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
    int          n;
    logic [63:0] ea [4];
    logic [7:0]  el [4];
  } rd_vec_t;

  rd_vec_t vecs [6];

  logic [63:0] ar_addr_q [$];
  logic [7:0]  ar_len_q  [$];
  logic [63:0] aw_addr_q [$];
  logic [7:0]  aw_len_q  [$];

  always @(posedge aclk) begin
    if (!areset && m_if.arvalid && m_if.arready) begin
      ar_addr_q.push_back(m_if.araddr);
      ar_len_q.push_back(m_if.arlen);
    end
    if (!areset && m_if.awvalid && m_if.awready) begin
      aw_addr_q.push_back(m_if.awaddr);
      aw_len_q.push_back(m_if.awlen);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_ar(input logic [63:0] addr, input logic [7:0] len);
    int ok;
    ok = 0;
    s_if.araddr  = addr;
    s_if.arlen   = len;
    s_if.arvalid = 1'b1;
    for (int i = 0; i < 60 && ok == 0; i++) begin
      #2;
      if (s_if.arready) ok = 1;
      @(negedge aclk);
    end
    s_if.arvalid = 1'b0;
    check("ar_accept", 64'(ok), 64'd1);
  endtask

  task automatic send_aw(input logic [63:0] addr, input logic [7:0] len);
    int ok;
    ok = 0;
    s_if.awaddr  = addr;
    s_if.awlen   = len;
    s_if.awvalid = 1'b1;
    for (int i = 0; i < 60 && ok == 0; i++) begin
      #2;
      if (s_if.awready) ok = 1;
      @(negedge aclk);
    end
    s_if.awvalid = 1'b0;
    check("aw_accept", 64'(ok), 64'd1);
  endtask

  task automatic send_w(input int beats, input int l1, input int l2);
    int b;
    int guard;
    b = 1;
    guard = 0;
    while (b <= beats && guard < 400) begin
      s_if.wvalid = 1'b1;
      s_if.wdata  = {16{32'(b)}};
      s_if.wstrb  = '1;
      s_if.wlast  = 1'($urandom);
      #2;
      if (s_if.wready) begin
        check("m_wlast", 64'(m_if.wlast), 64'((b == l1) || (b == l2)));
        b++;
      end
      guard++;
      @(negedge aclk);
    end
    s_if.wvalid = 1'b0;
    check("w_beats_done", 64'(b), 64'(beats + 1));
  endtask

  task automatic b_resp(input logic [1:0] r);
    m_if.bvalid = 1'b1;
    m_if.bresp  = r;
    #2;
    check("m_bready", 64'(m_if.bready), 64'd1);
    @(negedge aclk);
    m_if.bvalid = 1'b0;
  endtask

  task automatic drain_r(input rd_vec_t v);
    int b;
    b = 0;
    for (int k = 0; k < v.n; k++) begin
      for (int j = 0; j <= int'(v.el[k]); j++) begin
        m_if.rvalid = 1'b1;
        m_if.rlast  = (j == int'(v.el[k]));
        m_if.rdata  = {16{32'(b)}};
        #2;
        check("s_rlast", 64'(s_if.rlast), 64'((k == v.n - 1) && (j == int'(v.el[k]))));
        if (k == v.n - 1 && j == int'(v.el[k]))
          check("s_rdata_last", 64'(s_if.rdata[31:0]), 64'(b));
        @(negedge aclk);
        b++;
      end
    end
    m_if.rvalid = 1'b0;
    m_if.rlast  = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    areset = 1'b1;
    s_if.araddr = '0; s_if.arlen = '0; s_if.arvalid = 1'b0;
    s_if.awaddr = '0; s_if.awlen = '0; s_if.awvalid = 1'b0;
    s_if.wdata = '0; s_if.wstrb = '0; s_if.wlast = 1'b0; s_if.wvalid = 1'b0;
    s_if.rready = 1'b1; s_if.bready = 1'b0;
    m_if.arready = 1'b1; m_if.awready = 1'b1; m_if.wready = 1'b1;
    m_if.rdata = '0; m_if.rresp = '0; m_if.rlast = 1'b0; m_if.rvalid = 1'b0;
    m_if.bresp = '0; m_if.bvalid = 1'b0;

    vecs[0] = '{64'h0,     8'd63, 4, '{64'h0, 64'h400, 64'h800, 64'hC00}, '{8'd15, 8'd15, 8'd15, 8'd15}};
    vecs[1] = '{64'hFC0,   8'd3,  2, '{64'hFC0, 64'h1000, 64'h0, 64'h0},  '{8'd0, 8'd2, 8'd0, 8'd0}};
    vecs[2] = '{64'h2000,  8'd0,  1, '{64'h2000, 64'h0, 64'h0, 64'h0},    '{8'd0, 8'd0, 8'd0, 8'd0}};
    vecs[3] = '{64'hF00,   8'd31, 3, '{64'hF00, 64'h1000, 64'h1400, 64'h0}, '{8'd3, 8'd15, 8'd11, 8'd0}};
    vecs[4] = '{64'h3000,  8'd15, 1, '{64'h3000, 64'h0, 64'h0, 64'h0},    '{8'd15, 8'd0, 8'd0, 8'd0}};
    vecs[5] = '{64'h10000, 8'd16, 2, '{64'h10000, 64'h10400, 64'h0, 64'h0}, '{8'd15, 8'd0, 8'd0, 8'd0}};

    // reset state
    repeat (2) @(negedge aclk);
    #2;
    check("rst_s_arready", 64'(s_if.arready), 64'd0);
    check("rst_s_awready", 64'(s_if.awready), 64'd0);
    check("rst_m_arvalid", 64'(m_if.arvalid), 64'd0);
    check("rst_m_awvalid", 64'(m_if.awvalid), 64'd0);
    check("rst_m_wvalid",  64'(m_if.wvalid),  64'd0);
    check("rst_s_bvalid",  64'(s_if.bvalid),  64'd0);
    check("rst_s_rvalid",  64'(s_if.rvalid),  64'd0);
    areset = 1'b0;
    @(negedge aclk);
    #2;
    check("post_rst_arready", 64'(s_if.arready), 64'd1);
    check("post_rst_awready", 64'(s_if.awready), 64'd1);
    @(negedge aclk);

    // table-driven read splits
    for (int t = 0; t < 6; t++) begin
      ar_addr_q.delete();
      ar_len_q.delete();
      send_ar(vecs[t].addr, vecs[t].len);
      for (int i = 0; i < 100 && ar_addr_q.size() < vecs[t].n; i++) @(negedge aclk);
      repeat (2) @(negedge aclk);
      check($sformatf("ar_count_v%0d", t), 64'(ar_addr_q.size()), 64'(vecs[t].n));
      for (int k = 0; k < vecs[t].n && k < ar_addr_q.size(); k++) begin
        check($sformatf("ar_addr_v%0d_%0d", t, k), ar_addr_q[k], vecs[t].ea[k]);
        check($sformatf("ar_len_v%0d_%0d", t, k), 64'(ar_len_q[k]), 64'(vecs[t].el[k]));
      end
      drain_r(vecs[t]);
    end

    // nine single-beat reads with no returning data: the ninth waits for a free RQ slot
    ar_addr_q.delete();
    ar_len_q.delete();
    for (int i = 0; i < 9; i++) send_ar(64'h8000 + 64'(i * 64), 8'd0);
    repeat (3) @(negedge aclk);
    #2;
    check("rq_full_ar_count", 64'(ar_addr_q.size()), 64'd8);
    check("rq_full_m_arvalid", 64'(m_if.arvalid), 64'd0);
    check("rq_full_s_arready", 64'(s_if.arready), 64'd0);
    @(negedge aclk);
    m_if.rvalid = 1'b1;
    m_if.rlast  = 1'b1;
    #2;
    check("rq_drain_rlast", 64'(s_if.rlast), 64'd1);
    @(negedge aclk);
    m_if.rvalid = 1'b0;
    m_if.rlast  = 1'b0;
    #2;
    check("rq_freed_m_arvalid", 64'(m_if.arvalid), 64'd1);
    @(negedge aclk);
    check("rq_freed_ar_count", 64'(ar_addr_q.size()), 64'd9);
    if (ar_addr_q.size() == 9) check("rq_ninth_addr", ar_addr_q[8], 64'h8200);
    for (int i = 0; i < 8; i++) begin
      m_if.rvalid = 1'b1;
      m_if.rlast  = 1'b1;
      #2;
      check("rq_single_rlast", 64'(s_if.rlast), 64'd1);
      @(negedge aclk);
    end
    m_if.rvalid = 1'b0;
    m_if.rlast  = 1'b0;

    // write split with wlast regeneration and merged response
    aw_addr_q.delete();
    aw_len_q.delete();
    send_aw(64'h100, 8'd19);
    send_w(20, 16, 20);
    check("aw_split_count", 64'(aw_addr_q.size()), 64'd2);
    if (aw_addr_q.size() == 2) begin
      check("aw0_addr", aw_addr_q[0], 64'h100);
      check("aw0_len",  64'(aw_len_q[0]), 64'd15);
      check("aw1_addr", aw_addr_q[1], 64'h500);
      check("aw1_len",  64'(aw_len_q[1]), 64'd3);
    end
    b_resp(2'd0);
    #2;
    check("b_mid_s_bvalid", 64'(s_if.bvalid), 64'd0);
    @(negedge aclk);
    b_resp(2'd2);
    #2;
    check("b_final_s_bvalid", 64'(s_if.bvalid), 64'd1);
    check("b_final_s_bresp",  64'(s_if.bresp),  64'd2);
    check("b_hold_m_bready",  64'(m_if.bready), 64'd0);
    @(negedge aclk);
    #2;
    check("b_held_s_bvalid", 64'(s_if.bvalid), 64'd1);
    @(negedge aclk);
    s_if.bready = 1'b1;
    @(negedge aclk);
    s_if.bready = 1'b0;
    #2;
    check("b_done_s_bvalid", 64'(s_if.bvalid), 64'd0);
    check("b_done_m_bready", 64'(m_if.bready), 64'd1);
    @(negedge aclk);

    // single-beat write with downstream AW stalled for five cycles
    aw_addr_q.delete();
    aw_len_q.delete();
    m_if.awready = 1'b0;
    send_aw(64'h40, 8'd0);
    for (int i = 0; i < 5; i++) begin
      #2;
      check("stall_s_awready", 64'(s_if.awready), 64'd0);
      check("stall_m_awvalid", 64'(m_if.awvalid), 64'd1);
      @(negedge aclk);
    end
    check("stall_aw_count", 64'(aw_addr_q.size()), 64'd0);
    m_if.awready = 1'b1;
    @(negedge aclk);
    #2;
    check("unstall_aw_count", 64'(aw_addr_q.size()), 64'd1);
    check("unstall_m_awvalid", 64'(m_if.awvalid), 64'd0);
    check("unstall_s_awready", 64'(s_if.awready), 64'd1);
    if (aw_addr_q.size() == 1) begin
      check("unstall_aw_addr", aw_addr_q[0], 64'h40);
      check("unstall_aw_len", 64'(aw_len_q[0]), 64'd0);
    end
    @(negedge aclk);
    send_w(1, 1, 1);
    b_resp(2'd1);
    #2;
    check("single_s_bvalid", 64'(s_if.bvalid), 64'd1);
    check("single_s_bresp",  64'(s_if.bresp),  64'd1);
    @(negedge aclk);
    s_if.bready = 1'b1;
    @(negedge aclk);
    s_if.bready = 1'b0;

    // reset in the middle of a write burst
    aw_addr_q.delete();
    aw_len_q.delete();
    send_aw(64'h0, 8'd7);
    send_w(3, 0, 0);
    m_if.awready = 1'b0;
    send_aw(64'h1000, 8'd0);
    s_if.wvalid = 1'b1;
    #2;
    check("pre_rst_m_awvalid", 64'(m_if.awvalid), 64'd1);
    check("pre_rst_m_wvalid",  64'(m_if.wvalid),  64'd1);
    areset = 1'b1;
    #1;
    check("mid_rst_m_awvalid", 64'(m_if.awvalid), 64'd0);
    check("mid_rst_m_wvalid",  64'(m_if.wvalid),  64'd0);
    check("mid_rst_m_arvalid", 64'(m_if.arvalid), 64'd0);
    check("mid_rst_s_awready", 64'(s_if.awready), 64'd0);
    check("mid_rst_s_bvalid",  64'(s_if.bvalid),  64'd0);
    s_if.wvalid  = 1'b0;
    m_if.awready = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    #2;
    check("rel_s_awready", 64'(s_if.awready), 64'd1);
    @(negedge aclk);
    aw_addr_q.delete();
    aw_len_q.delete();
    send_aw(64'h2000, 8'd0);
    send_w(1, 1, 1);
    check("fresh_aw_count", 64'(aw_addr_q.size()), 64'd1);
    if (aw_addr_q.size() == 1) begin
      check("fresh_aw_addr", aw_addr_q[0], 64'h2000);
      check("fresh_aw_len",  64'(aw_len_q[0]), 64'd0);
    end
    b_resp(2'd0);
    #2;
    check("fresh_s_bvalid", 64'(s_if.bvalid), 64'd1);
    check("fresh_s_bresp",  64'(s_if.bresp),  64'd0);
    @(negedge aclk);
    s_if.bready = 1'b1;
    @(negedge aclk);
    s_if.bready = 1'b0;
    #2;
    check("fresh_b_done", 64'(s_if.bvalid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
